// File: rtl/unified_mem_arb_pkg.sv
// Shared types and constants for the unified memory arbiter.
//   arb_state_t : arbiter FSM state (IDLE / BUSY)
//   owner_t     : which requester owns the outstanding access
//   DEF_MEM_LAT : default issue-to-data latency of the memory macro
//   LAT_CNT_W   : width of the latency counter (covers MEM_LAT 1..15)
//   sat_inc16   : saturating 16-bit increment for the wait counters
package unified_mem_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_t;

    localparam int DEF_MEM_LAT = 2;
    localparam int LAT_CNT_W   = 4;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/unified_mem_arb_if.sv
// Bus bundle between the cpu pipeline, the arbiter and the memory macro.
//   Fetch side : if_req/if_addr in, if_gnt/if_rvalid/if_rdata out
//   Data side  : dm_req/dm_we/dm_addr/dm_wdata in, dm_gnt/dm_rvalid/dm_rdata out
//   Memory side: mem_en/mem_we/mem_addr/mem_wdata out, mem_rdata in
//   stall      : pipeline freeze
// modport slave  : the arbiter's view
// modport master : the environment's view (pipeline + memory macro)
// A requester keeps req and its payload stable while its access is
// outstanding. In its rvalid cycle the pipeline is released, so req and the
// payload already describe the requester's next access (or req is low); a
// req still high in that cycle is taken as a new request.
interface unified_mem_arb_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic [DATA_W-1:0] dm_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              stall;

    modport slave (
        input  if_req, if_addr,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        input  mem_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output dm_gnt, dm_rvalid, dm_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output stall
    );

    modport master (
        output if_req, if_addr,
        output dm_req, dm_we, dm_addr, dm_wdata,
        output mem_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  dm_gnt, dm_rvalid, dm_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  stall
    );
endinterface

// File: rtl/unified_mem_arb_mem_lat_timer.sv
// mem_lat_timer: counts the cycles of the outstanding memory access.
//   clk, rst_n : clock, asynchronous active-low reset (count -> 0)
//   load       : access issued this cycle; count restarts at 0
//   run        : an access is outstanding; count advances until done
//   done       : count == MEM_LAT-1, i.e. this is the completion cycle
module mem_lat_timer
    import unified_mem_arb_pkg::*;
#(
    parameter int MEM_LAT = DEF_MEM_LAT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic run,
    output logic done
);
    localparam logic [LAT_CNT_W-1:0] LAST = LAT_CNT_W'(MEM_LAT - 1);

    logic [LAT_CNT_W-1:0] count_q, count_d;

    assign done = (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = '0;
        end else if (run && !done) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end
endmodule

// File: rtl/unified_mem_arb.sv
// unified_mem_arb: shares one single-ported memory between IF-stage fetch
// and MEM-stage load/store. Data beats fetch (the MEM-stage instruction is
// older). One access is outstanding at a time; the next one may issue in the
// completion cycle of the current one, giving one access per MEM_LAT cycles.
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : unified_mem_arb_if.slave (fetch, data, memory, stall)
//   perf_if_wait, perf_dm_wait : saturating wait-cycle counters, present
//                 only when UMA_PERF_CNT_EN is defined
// Parameters: ADDR_W, DATA_W, MEM_LAT (legal 1..15).
module unified_mem_arb
    import unified_mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = DEF_MEM_LAT
) (
    input  logic clk,
    input  logic rst_n,
    unified_mem_arb_if.slave bus
`ifdef UMA_PERF_CNT_EN
    ,
    output logic [15:0] perf_if_wait,
    output logic [15:0] perf_dm_wait
`endif
);
    arb_state_t state_q, state_d;
    owner_t     owner_q, owner_d;

    logic lat_done;
    logic complete;
    logic issue_slot;
    logic grant_dm;
    logic grant_if;
    logic issue;
    logic if_rvalid;
    logic dm_rvalid;

    mem_lat_timer #(.MEM_LAT(MEM_LAT)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (issue),
        .run   (state_q == BUSY),
        .done  (lat_done)
    );

    // Arbitration and next state. Issue is gated by rst_n so that nothing
    // leaves the block while reset is held, even with requests pending.
    always_comb begin
        complete   = (state_q == BUSY) && lat_done;
        issue_slot = rst_n && ((state_q == IDLE) || complete);
        grant_dm   = issue_slot && bus.dm_req;
        grant_if   = issue_slot && bus.if_req && !bus.dm_req;
        issue      = grant_dm || grant_if;

        state_d = state_q;
        owner_d = owner_q;
        if (issue) begin
            state_d = BUSY;
            owner_d = grant_dm ? OWN_DM : OWN_IF;
        end else if (complete) begin
            state_d = IDLE;
            owner_d = OWN_NONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= OWN_NONE;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    // Memory strobe and payload follow the decision combinationally and are
    // held at 0 outside issue cycles. Read data is passed through only in the
    // owner's completion cycle.
    always_comb begin
        if_rvalid = complete && (owner_q == OWN_IF);
        dm_rvalid = complete && (owner_q == OWN_DM);

        bus.if_gnt    = grant_if;
        bus.dm_gnt    = grant_dm;
        bus.mem_en    = issue;
        bus.mem_we    = grant_dm && bus.dm_we;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (grant_dm) begin
            bus.mem_addr  = bus.dm_addr;
            bus.mem_wdata = bus.dm_wdata;
        end else if (grant_if) begin
            bus.mem_addr  = bus.if_addr;
        end

        bus.if_rvalid = if_rvalid;
        bus.dm_rvalid = dm_rvalid;
        bus.if_rdata  = if_rvalid ? bus.mem_rdata : '0;
        bus.dm_rdata  = dm_rvalid ? bus.mem_rdata : '0;

        // Released in the completion cycle so the pipeline advances with
        // the returning data.
        bus.stall = rst_n && ((bus.if_req && !if_rvalid) ||
                              (bus.dm_req && !dm_rvalid));
    end

`ifdef UMA_PERF_CNT_EN
    logic [15:0] perf_if_wait_q, perf_if_wait_d;
    logic [15:0] perf_dm_wait_q, perf_dm_wait_d;

    always_comb begin
        perf_if_wait_d = perf_if_wait_q;
        perf_dm_wait_d = perf_dm_wait_q;
        if (bus.if_req && !if_rvalid) perf_if_wait_d = sat_inc16(perf_if_wait_q);
        if (bus.dm_req && !dm_rvalid) perf_dm_wait_d = sat_inc16(perf_dm_wait_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_if_wait_q <= '0;
            perf_dm_wait_q <= '0;
        end else begin
            perf_if_wait_q <= perf_if_wait_d;
            perf_dm_wait_q <= perf_dm_wait_d;
        end
    end

    assign perf_if_wait = perf_if_wait_q;
    assign perf_dm_wait = perf_dm_wait_q;
`endif
endmodule

// File: tb/tb_unified_mem_arb.sv
// Bench for unified_mem_arb: instance 0 with MEM_LAT=2, instance 1 with
// MEM_LAT=1, each with a small memory model. Expected read data is queued
// when a request is driven and checked when rvalid appears.
module tb_unified_mem_arb;
    localparam int AW = 16;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fails = 0;

    unified_mem_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
    unified_mem_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

`ifdef UMA_PERF_CNT_EN
    logic [15:0] perf_if0, perf_dm0, perf_if1, perf_dm1;
`endif

    unified_mem_arb #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(2)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
`ifdef UMA_PERF_CNT_EN
        ,
        .perf_if_wait (perf_if0),
        .perf_dm_wait (perf_dm0)
`endif
    );

    unified_mem_arb #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
`ifdef UMA_PERF_CNT_EN
        ,
        .perf_if_wait (perf_if1),
        .perf_dm_wait (perf_dm1)
`endif
    );

    function automatic logic [15:0] pat(input logic [15:0] a);
        return {8'hC3 ^ a[7:0], a[7:0]};
    endfunction

    // Memory models: read data appears MEM_LAT cycles after mem_en.
    logic [15:0] mem0 [0:255];
    logic [15:0] mem1 [0:255];
    logic [15:0] rd0_a, rd0_b, rd1_a;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem0[i] <= pat(16'(i));
        end else if (bus0.mem_en && bus0.mem_we) begin
            mem0[bus0.mem_addr[7:0]] <= bus0.mem_wdata;
        end
        rd0_a <= mem0[bus0.mem_addr[7:0]];
        rd0_b <= rd0_a;
    end
    assign bus0.mem_rdata = rd0_b;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem1[i] <= pat(16'(i));
        end else if (bus1.mem_en && bus1.mem_we) begin
            mem1[bus1.mem_addr[7:0]] <= bus1.mem_wdata;
        end
        rd1_a <= mem1[bus1.mem_addr[7:0]];
    end
    assign bus1.mem_rdata = rd1_a;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard
    typedef struct packed {
        logic        chk;
        logic [15:0] d;
    } exp_t;

    exp_t if_q0[$];
    exp_t dm_q0[$];
    exp_t if_q1[$];
    logic sb_en = 1'b1;

    always @(negedge clk) begin : sb_mon
        exp_t e;
        if (rst_n && sb_en) begin
            if (bus0.if_rvalid) begin
                n_tests++;
                assert (if_q0.size() != 0) else begin
                    n_fails++;
                    $error("FAIL if0_spurious_rvalid: observed rvalid expected none");
                end
                if (if_q0.size() != 0) begin
                    e = if_q0.pop_front();
                    if (e.chk) chk("if0_rdata", 32'(bus0.if_rdata), 32'(e.d));
                end
            end
            if (bus0.dm_rvalid) begin
                n_tests++;
                assert (dm_q0.size() != 0) else begin
                    n_fails++;
                    $error("FAIL dm0_spurious_rvalid: observed rvalid expected none");
                end
                if (dm_q0.size() != 0) begin
                    e = dm_q0.pop_front();
                    if (e.chk) chk("dm0_rdata", 32'(bus0.dm_rdata), 32'(e.d));
                end
            end
            if (bus1.if_rvalid) begin
                n_tests++;
                assert (if_q1.size() != 0) else begin
                    n_fails++;
                    $error("FAIL if1_spurious_rvalid: observed rvalid expected none");
                end
                if (if_q1.size() != 0) begin
                    e = if_q1.pop_front();
                    if (e.chk) chk("if1_rdata", 32'(bus1.if_rdata), 32'(e.d));
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        bus0.if_req = 1'b1; bus0.if_addr = 16'h1234;
        bus0.dm_req = 1'b1; bus0.dm_we = 1'b1; bus0.dm_addr = 16'h4321; bus0.dm_wdata = 16'hFFFF;
        bus1.if_req = 1'b1; bus1.if_addr = 16'h0001;
        bus1.dm_req = 1'b0; bus1.dm_we = 1'b0; bus1.dm_addr = '0; bus1.dm_wdata = '0;

        // Reset with requests pending: every output 0
        repeat (3) @(posedge clk);
        smp();
        chk("rst_if_gnt",    32'(bus0.if_gnt), 0);
        chk("rst_dm_gnt",    32'(bus0.dm_gnt), 0);
        chk("rst_mem_en",    32'(bus0.mem_en), 0);
        chk("rst_mem_we",    32'(bus0.mem_we), 0);
        chk("rst_mem_addr",  32'(bus0.mem_addr), 0);
        chk("rst_mem_wdata", 32'(bus0.mem_wdata), 0);
        chk("rst_stall",     32'(bus0.stall), 0);
        chk("rst_rvalids",   32'({bus0.if_rvalid, bus0.dm_rvalid}), 0);
        chk("rst1_mem_en",   32'(bus1.mem_en), 0);
        chk("rst1_stall",    32'(bus1.stall), 0);
`ifdef UMA_PERF_CNT_EN
        chk("rst_perf_if",   32'(perf_if0), 0);
`endif
        bus0.if_req = 1'b0; bus0.if_addr = '0;
        bus0.dm_req = 1'b0; bus0.dm_we = 1'b0; bus0.dm_addr = '0; bus0.dm_wdata = '0;
        bus1.if_req = 1'b0; bus1.if_addr = '0;
        cyc(); rst_n = 1'b1;
        cyc();

        // Test 1: fetch alone; a DM pulse withdrawn before any slot
        cyc(); bus0.if_req = 1'b1; bus0.if_addr = 16'h0010;
        if_q0.push_back('{chk: 1'b1, d: pat(16'h0010)});
        smp();
        chk("t1_if_gnt",   32'(bus0.if_gnt), 1);
        chk("t1_mem_en",   32'(bus0.mem_en), 1);
        chk("t1_mem_addr", 32'(bus0.mem_addr), 32'h0010);
        chk("t1_mem_we",   32'(bus0.mem_we), 0);
        chk("t1_stall_T",  32'(bus0.stall), 1);
        cyc(); bus0.dm_req = 1'b1; bus0.dm_addr = 16'h0077;
        smp();
        chk("t1_no_issue_T1", 32'({bus0.if_gnt, bus0.dm_gnt, bus0.mem_en}), 0);
        chk("t1_mem_addr_T1", 32'(bus0.mem_addr), 0);
        chk("t1_stall_T1",    32'(bus0.stall), 1);
        cyc(); bus0.dm_req = 1'b0; bus0.if_req = 1'b0;
        smp();
        chk("t1_if_rvalid",  32'(bus0.if_rvalid), 1);
        chk("t1_dm_rvalid",  32'(bus0.dm_rvalid), 0);
        chk("t1_no_issue_T2", 32'(bus0.mem_en), 0);
        chk("t1_stall_T2",   32'(bus0.stall), 0);
        cyc(); smp();
        chk("t1_rvalid_T3",  32'(bus0.if_rvalid), 0);

        // Test 2: simultaneous fetch and load, DM first
        cyc(); bus0.if_req = 1'b1; bus0.if_addr = 16'h0030;
        bus0.dm_req = 1'b1; bus0.dm_we = 1'b0; bus0.dm_addr = 16'h0040;
        dm_q0.push_back('{chk: 1'b1, d: pat(16'h0040)});
        if_q0.push_back('{chk: 1'b1, d: pat(16'h0030)});
        smp();
        chk("t2_dm_gnt_T",   32'(bus0.dm_gnt), 1);
        chk("t2_if_gnt_T",   32'(bus0.if_gnt), 0);
        chk("t2_mem_addr_T", 32'(bus0.mem_addr), 32'h0040);
        chk("t2_stall_T",    32'(bus0.stall), 1);
        cyc(); smp();
        chk("t2_gnt_T1",     32'({bus0.if_gnt, bus0.dm_gnt}), 0);
        chk("t2_stall_T1",   32'(bus0.stall), 1);
        cyc(); bus0.dm_req = 1'b0;
        smp();
        chk("t2_dm_rvalid_T2", 32'(bus0.dm_rvalid), 1);
        chk("t2_if_rvalid_T2", 32'(bus0.if_rvalid), 0);
        chk("t2_if_gnt_T2",    32'(bus0.if_gnt), 1);
        chk("t2_mem_addr_T2",  32'(bus0.mem_addr), 32'h0030);
        chk("t2_stall_T2",     32'(bus0.stall), 1);
        cyc(); smp();
        chk("t2_stall_T3",     32'(bus0.stall), 1);
        chk("t2_if_gnt_T3",    32'(bus0.if_gnt), 0);
        cyc(); bus0.if_req = 1'b0;
        smp();
        chk("t2_if_rvalid_T4", 32'(bus0.if_rvalid), 1);
        chk("t2_stall_T4",     32'(bus0.stall), 0);
        cyc(); smp();

        // Test 3: store BEEF, reload issued in the store's completion cycle
        cyc(); bus0.dm_req = 1'b1; bus0.dm_we = 1'b1;
        bus0.dm_addr = 16'h0020; bus0.dm_wdata = 16'hBEEF;
        dm_q0.push_back('{chk: 1'b0, d: 16'h0000});
        smp();
        chk("t3_mem_we",    32'(bus0.mem_we), 1);
        chk("t3_mem_wdata", 32'(bus0.mem_wdata), 32'hBEEF);
        chk("t3_mem_addr",  32'(bus0.mem_addr), 32'h0020);
        cyc(); smp();
        chk("t3_idle_wdata", 32'(bus0.mem_wdata), 0);
        cyc(); bus0.dm_we = 1'b0; bus0.dm_wdata = '0;
        dm_q0.push_back('{chk: 1'b1, d: 16'hBEEF});
        smp();
        chk("t3_st_rvalid", 32'(bus0.dm_rvalid), 1);
        chk("t3_ld_gnt",    32'(bus0.dm_gnt), 1);
        chk("t3_ld_we",     32'(bus0.mem_we), 0);
        cyc(); smp();
        cyc(); bus0.dm_req = 1'b0;
        smp();
        chk("t3_ld_rvalid", 32'(bus0.dm_rvalid), 1);
        cyc(); smp();

        // Test 4: MEM_LAT=1, continuous fetch with changing address
        cyc(); bus1.if_req = 1'b1; bus1.if_addr = 16'h0080;
        if_q1.push_back('{chk: 1'b1, d: pat(16'h0080)});
        smp();
        chk("t4_gnt_first",   32'(bus1.if_gnt), 1);
        chk("t4_rvalid_first", 32'(bus1.if_rvalid), 0);
        for (int k = 1; k < 6; k++) begin
            cyc(); bus1.if_addr = 16'h0080 + 16'(k);
            if_q1.push_back('{chk: 1'b1, d: pat(16'h0080 + 16'(k))});
            smp();
            chk("t4_gnt",      32'(bus1.if_gnt), 1);
            chk("t4_rvalid",   32'(bus1.if_rvalid), 1);
            chk("t4_mem_addr", 32'(bus1.mem_addr), 32'h0080 + k);
            chk("t4_stall",    32'(bus1.stall), 0);
        end
        cyc(); bus1.if_req = 1'b0;
        smp();
        chk("t4_rvalid_last", 32'(bus1.if_rvalid), 1);
        chk("t4_gnt_last",    32'(bus1.if_gnt), 0);
        cyc(); smp();
        chk("t4_idle",        32'(bus1.if_rvalid), 0);

        // Test 5: reset one cycle after a DM issue abandons the access
        cyc(); bus0.dm_req = 1'b1; bus0.dm_we = 1'b0; bus0.dm_addr = 16'h0050;
        dm_q0.push_back('{chk: 1'b1, d: pat(16'h0050)});
        smp();
        chk("t5_dm_gnt", 32'(bus0.dm_gnt), 1);
        cyc(); rst_n = 1'b0; bus0.if_req = 1'b1; bus0.if_addr = 16'h0055;
        smp();
        dm_q0.delete();
        chk("t5_rst_outs", 32'({bus0.if_gnt, bus0.dm_gnt, bus0.mem_en, bus0.mem_we,
                                bus0.if_rvalid, bus0.dm_rvalid, bus0.stall}), 0);
        chk("t5_rst_addr", 32'(bus0.mem_addr), 0);
        chk("t5_rst_rdata", 32'({bus0.if_rdata, bus0.dm_rdata}), 0);
        cyc(); rst_n = 1'b1; bus0.dm_req = 1'b0; bus0.if_req = 1'b0;
        smp();
        chk("t5_no_rvalid_T2", 32'(bus0.dm_rvalid), 0);
        chk("t5_no_issue_T2",  32'(bus0.mem_en), 0);
        cyc(); smp();
        chk("t5_no_rvalid_T3", 32'(bus0.dm_rvalid), 0);
        // Next request issues normally; req dropped after grant still completes
        cyc(); bus0.dm_req = 1'b1; bus0.dm_addr = 16'h0060;
        dm_q0.push_back('{chk: 1'b1, d: pat(16'h0060)});
        smp();
        chk("t5_new_gnt",  32'(bus0.dm_gnt), 1);
        chk("t5_new_addr", 32'(bus0.mem_addr), 32'h0060);
        cyc(); bus0.dm_req = 1'b0;
        smp();
        chk("t5_drop_stall", 32'(bus0.stall), 0);
        chk("t5_drop_gnt",   32'(bus0.dm_gnt), 0);
        cyc(); smp();
        chk("t5_new_rvalid", 32'(bus0.dm_rvalid), 1);
        cyc(); smp();
        chk("t5_rvalid_end", 32'(bus0.dm_rvalid), 0);

`ifdef UMA_PERF_CNT_EN
        // Test 6: fetch blocked by continuous DM traffic saturates its counter
        sb_en = 1'b0;
        cyc(); bus0.dm_req = 1'b1; bus0.dm_we = 1'b0; bus0.dm_addr = 16'h0011;
        bus0.if_req = 1'b1; bus0.if_addr = 16'h0012;
        repeat (70000) cyc();
        smp();
        chk("t6_perf_if_sat", 32'(perf_if0), 32'hFFFF);
        chk("t6_if_never_gnt", 32'(bus0.if_rvalid), 0);
        cyc(); bus0.dm_req = 1'b0; bus0.if_req = 1'b0;
        repeat (4) cyc();
`endif

        smp();
        chk("end_if0_q", 32'(if_q0.size()), 0);
        chk("end_dm0_q", 32'(dm_q0.size()), 0);
        chk("end_if1_q", 32'(if_q1.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end
endmodule
